// File: rtl/scan_pkg.sv
// ============================================================================
// Module : scan_pkg
// Brief  : Shared constants, state type and hex-to-7-segment lookup for the
//          8-digit scan controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scan_pkg;

    localparam int         NUM_DIG    = 8;
    localparam logic [2:0] SEL_EN_ON  = 3'b100;
    localparam logic [2:0] SEL_EN_OFF = 3'b000;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_ctrl_8dig_hex2seg7.sv
// ============================================================================
// Module : hex2seg7
// Brief  : Combinational nibble to active-low seven-segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex2seg7
    import scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_nib);

endmodule

`default_nettype wire

// File: rtl/scan_ctrl_8dig.sv
// ============================================================================
// Module : scan_ctrl_8dig
// Brief  : Time-multiplexed scan controller for an 8-digit seven-segment
//          display with frame-aligned shadow-register value updates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_ctrl_8dig
    import scan_pkg::*;
#(
    parameter int DIV_CNT = 100000
)
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] value_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  blank_i,
    output logic [2:0]  sel_o,
    output logic [2:0]  sel_en_o,
    output logic [7:0]  seg_o,
    output logic        load_ack_o
);

    localparam int              PW          = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [PW-1:0]   c_PRESC_MAX = PW'(DIV_CNT - 1);

    scan_state_e          r_state_q,  w_state_d;
    logic [PW-1:0]        r_presc_q,  w_presc_d;
    logic [2:0]           r_sel_q,    w_sel_d;
    logic [2:0]           r_sel_en_q, w_sel_en_d;
    logic [7:0]           r_seg_q,    w_seg_d;
    logic                 r_ack_q,    w_ack_d;
    logic [31:0]          r_val_q,    w_val_d;
    logic [NUM_DIG-1:0]   r_dp_q,     w_dp_d;
    logic [31:0]          r_sh_val_q, w_sh_val_d;
    logic [NUM_DIG-1:0]   r_sh_dp_q,  w_sh_dp_d;
    logic                 r_pend_q,   w_pend_d;

    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_apply;
    logic [3:0]           w_nib;
    logic [6:0]           w_seg7;

    assign w_tick     = (r_state_q == ST_SCAN) && (r_presc_q == c_PRESC_MAX);
    assign w_boundary = en_i && w_tick && (r_sel_q == 3'd7);
    // While dark there is no frame to tear, so a pending value lands at once
    assign w_apply    = r_pend_q && ((r_state_q == ST_OFF) || w_boundary);

    // Segment data is looked up from next-state sel/display so it tracks sel_o
    assign w_nib = w_val_d[{w_sel_d, 2'b00} +: 4];

    hex2seg7 u_hex2seg7 (
        .i_nib (w_nib),
        .o_seg (w_seg7)
    );

    always_comb begin
        w_state_d  = en_i ? ST_SCAN : ST_OFF;
        w_presc_d  = r_presc_q;
        w_sel_d    = r_sel_q;
        w_sel_en_d = en_i ? SEL_EN_ON : SEL_EN_OFF;
        w_val_d    = r_val_q;
        w_dp_d     = r_dp_q;
        w_sh_val_d = r_sh_val_q;
        w_sh_dp_d  = r_sh_dp_q;
        w_pend_d   = r_pend_q;
        w_ack_d    = w_apply;
        w_seg_d    = SEG_BLANK;

        if (!en_i) begin
            w_presc_d = '0;
            w_sel_d   = 3'd0;
        end else if (r_state_q == ST_SCAN) begin
            if (w_tick) begin
                w_presc_d = '0;
                w_sel_d   = r_sel_q + 3'd1;
            end else begin
                w_presc_d = r_presc_q + 1'b1;
            end
        end

        if (w_apply) begin
            w_val_d  = r_sh_val_q;
            w_dp_d   = r_sh_dp_q;
            w_pend_d = 1'b0;
        end

        // A load coinciding with an apply is queued for the following boundary
        if (load_i) begin
            w_sh_val_d = value_i;
            w_sh_dp_d  = dp_i;
            w_pend_d   = 1'b1;
        end

        if (en_i && !blank_i[w_sel_d]) begin
            w_seg_d = {~w_dp_d[w_sel_d], w_seg7};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state_q  <= ST_OFF;
            r_presc_q  <= '0;
            r_sel_q    <= 3'd0;
            r_sel_en_q <= SEL_EN_OFF;
            r_seg_q    <= SEG_BLANK;
            r_ack_q    <= 1'b0;
            r_val_q    <= '0;
            r_dp_q     <= '0;
            r_sh_val_q <= '0;
            r_sh_dp_q  <= '0;
            r_pend_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_presc_q  <= w_presc_d;
            r_sel_q    <= w_sel_d;
            r_sel_en_q <= w_sel_en_d;
            r_seg_q    <= w_seg_d;
            r_ack_q    <= w_ack_d;
            r_val_q    <= w_val_d;
            r_dp_q     <= w_dp_d;
            r_sh_val_q <= w_sh_val_d;
            r_sh_dp_q  <= w_sh_dp_d;
            r_pend_q   <= w_pend_d;
        end
    end

    assign sel_o      = r_sel_q;
    assign sel_en_o   = r_sel_en_q;
    assign seg_o      = r_seg_q;
    assign load_ack_o = r_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_ctrl_8dig.sv
// ============================================================================
// Module : tb_scan_ctrl_8dig
// Brief  : Self-checking bench for scan_ctrl_8dig with a frame-time reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_ctrl_8dig;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [2:0]  sel;
    logic [2:0]  sel_en;
    logic [7:0]  seg;
    logic        ack;

    int vectors     = 0;
    int miscompares = 0;

    scan_ctrl_8dig #(.DIV_CNT(DIV)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .load_i     (load),
        .value_i    (value),
        .dp_i       (dp),
        .blank_i    (blank),
        .sel_o      (sel),
        .sel_en_o   (sel_en),
        .seg_o      (seg),
        .load_ack_o (ack)
    );

    always #5 clk = ~clk;

    // Reference: time since scan start within a frame, plus displayed/shadow copies
    logic [7:0]  tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    bit          m_on;
    int          m_t;
    logic [31:0] m_val, m_sh_val;
    logic [7:0]  m_dp, m_sh_dp;
    bit          m_pend;
    logic [2:0]  e_sel, e_sel_en;
    logic [7:0]  e_seg;
    logic        e_ack;

    function automatic logic [7:0] pat(input int d, input logic [31:0] v,
                                       input logic [7:0] p, input logic [7:0] b);
        logic [7:0] s;
        if (b[d]) return 8'hFF;
        s    = tab[v[4*d +: 4]];
        s[7] = ~p[d];
        return s;
    endfunction

    task automatic model_reset();
        m_on = 0; m_t = 0; m_pend = 0;
        m_val = '0; m_dp = '0; m_sh_val = '0; m_sh_dp = '0;
    endtask

    task automatic model_step();
        bit boundary, apply;
        boundary = m_on && en && (m_t == FRAME - 1);
        apply    = m_pend && (!m_on || boundary);
        if (apply) begin
            m_val = m_sh_val; m_dp = m_sh_dp; m_pend = 0;
        end
        e_ack = apply;
        if (load) begin
            m_sh_val = value; m_sh_dp = dp; m_pend = 1;
        end
        m_t      = (en && m_on) ? (m_t + 1) % FRAME : 0;
        m_on     = en;
        e_sel    = en ? 3'(m_t / DIV) : 3'd0;
        e_sel_en = en ? 3'b100 : 3'b000;
        e_seg    = en ? pat(m_t / DIV, m_val, m_dp, blank) : 8'hFF;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model_sel",    32'(sel),    32'(e_sel));
        check("model_sel_en", 32'(sel_en), 32'(e_sel_en));
        check("model_seg",    32'(seg),    32'(e_seg));
        check("model_ack",    32'(ack),    32'(e_ack));
    endtask

    task automatic wait_ack(input int limit, output bit ok);
        ok = 0;
        for (int n = 0; n < limit && !ok; n++) begin
            cyc();
            ok = ack;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ack_timeout: got no ack, expected ack within %0d cycles", limit);
        end
    endtask

    task automatic wait_sel(input logic [2:0] s);
        bit ok;
        ok = 0;
        for (int n = 0; n < 3 * FRAME && !ok; n++) begin
            cyc();
            ok = (sel == s);
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL sel_timeout: got sel %0d, expected sel %0d", sel, s);
        end
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] d);
        value = v; dp = d; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [63:0] exp;   // digit k pattern at [8k +: 8]
    } vec_t;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vec_t tbl [4];
        bit   ok;
        int   acks;

        tbl[0] = '{value: 32'h76543210, dp: 8'h00, blank: 8'h00, exp: 64'hF8_82_92_99_B0_A4_F9_C0};
        tbl[1] = '{value: 32'h00000000, dp: 8'h01, blank: 8'hF0, exp: 64'hFF_FF_FF_FF_C0_C0_C0_40};
        tbl[2] = '{value: 32'h00000000, dp: 8'h01, blank: 8'h0F, exp: 64'hC0_C0_C0_C0_FF_FF_FF_FF};
        tbl[3] = '{value: 32'hFEDCBA98, dp: 8'hAA, blank: 8'h00, exp: 64'h0E_86_21_C6_03_88_10_80};

        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp = '0; blank = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel",    32'(sel),    32'd0);
        check("rst_sel_en", 32'(sel_en), 32'd0);
        check("rst_seg",    32'(seg),    32'hFF);
        check("rst_ack",    32'(ack),    32'd0);
        rst_n = 1'b1;
        cyc();

        // Frame-aligned loads checked digit by digit against the table
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            blank = tbl[i].blank;
            pulse_load(tbl[i].value, tbl[i].dp);
            wait_ack(3 * FRAME, ok);
            if (ok) begin
                for (int k = 0; k < FRAME; k++) begin
                    check("tbl_sel",    32'(sel),    32'(k / DIV));
                    check("tbl_sel_en", 32'(sel_en), 32'h4);
                    check("tbl_seg",    32'(seg),    32'(tbl[i].exp[8*(k/DIV) +: 8]));
                    cyc();
                end
            end
        end

        // Mid-frame load: old digits finish the frame, then all-F appears
        blank = 8'h00;
        wait_sel(3'd3);
        pulse_load(32'hFFFFFFFF, 8'h00);
        wait_ack(2 * FRAME, ok);
        if (ok) begin
            for (int k = 0; k < FRAME; k++) begin
                check("midload_seg", 32'(seg), 32'h8E);
                cyc();
            end
        end

        // Two loads in one frame: last wins, single ack
        wait_sel(3'd1);
        pulse_load(32'h11111111, 8'h00);
        repeat (3) cyc();
        pulse_load(32'h88888888, 8'h00);
        acks = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cyc();
            if (ack) begin
                acks++;
                check("twoload_seg", 32'(seg), 32'h80);
            end
        end
        check("twoload_acks", 32'(acks), 32'd1);

        // Disable mid-frame, load while dark, re-enable
        wait_sel(3'd5);
        en = 1'b0;
        cyc();
        check("off_seg",    32'(seg),    32'hFF);
        check("off_sel_en", 32'(sel_en), 32'h0);
        check("off_sel",    32'(sel),    32'h0);
        pulse_load(32'h0000000A, 8'h00);
        cyc();
        check("off_ack", 32'(ack), 32'd1);
        en = 1'b1;
        cyc();
        check("reen_sel",    32'(sel),    32'h0);
        check("reen_sel_en", 32'(sel_en), 32'h4);
        check("reen_seg",    32'(seg),    32'h88);

        // Asynchronous reset mid-scan
        repeat (6) cyc();
        #3 rst_n = 1'b0;
        #1;
        check("arst_sel",    32'(sel),    32'd0);
        check("arst_sel_en", 32'(sel_en), 32'd0);
        check("arst_seg",    32'(seg),    32'hFF);
        check("arst_ack",    32'(ack),    32'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // Randomised traffic against the reference
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            load  = ($urandom_range(0, 15) == 0);
            value = $urandom;
            dp    = 8'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc();
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
